// File: rtl/nmea_sentence_assembler_if.sv
// Byte-stream input and assembled-sentence output bundle for the NMEA sentence assembler.
interface nmea_sentence_assembler_if #(
  parameter int unsigned SENTENCE_BITS = 1024
);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic [SENTENCE_BITS-1:0] sentence;
  logic [7:0]               sentence_len;
  logic                     sentence_valid;
  logic                     cksum_err;
  logic                     frame_err;
  logic [15:0]              good_count;
  logic [15:0]              bad_count;

  modport master (
    output rx_data, rx_valid,
    input  sentence, sentence_len, sentence_valid, cksum_err, frame_err, good_count, bad_count
  );

  modport slave (
    input  rx_data, rx_valid,
    output sentence, sentence_len, sentence_valid, cksum_err, frame_err, good_count, bad_count
  );
endinterface

// File: rtl/nmea_sentence_assembler.sv
// Frames "$...*hh" NMEA sentences from a UART byte stream, verifies the XOR checksum and
// optional RMC type, and publishes accepted sentences as a zero-filled byte-packed vector.
module nmea_sentence_assembler #(
  parameter int unsigned SENTENCE_BITS = 1024,
  parameter bit          MATCH_RMC     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nmea_sentence_assembler_if.slave  bus
);
  localparam int unsigned MAX_BYTES = SENTENCE_BITS / 8;
  localparam logic [7:0]  MAX_CNT   = 8'(MAX_BYTES);
  localparam logic [7:0]  CH_DOLLAR = 8'h24;
  localparam logic [7:0]  CH_STAR   = 8'h2A;
  localparam logic [7:0]  CH_CR     = 8'h0D;
  localparam logic [7:0]  CH_LF     = 8'h0A;

  typedef enum logic [1:0] {IDLE, CAPTURE, CK_HI, CK_LO} state_t;

  state_t                   state, state_d;
  logic [SENTENCE_BITS-1:0] wbuf;
  logic [7:0]               wcnt;
  logic [7:0]               csum;
  logic [3:0]               hi;
  logic [SENTENCE_BITS-1:0] sentence;
  logic [7:0]               sentence_len;
  logic                     sentence_valid, cksum_err, frame_err;
  logic [15:0]              good_count, bad_count;

  logic                     start_c, store_c, take_hi_c, accept_c, ck_err_c, fr_err_c;
  logic                     rx_hex_c, rmc_ok_c;
  logic [3:0]               rx_nib_c;
  logic [7:0]               rx;

  assign rx = bus.rx_data;

  // Hex digit decode of the incoming byte (both letter cases)
  always_comb begin
    rx_hex_c = 1'b1;
    rx_nib_c = 4'h0;
    if (rx >= 8'h30 && rx <= 8'h39)      rx_nib_c = 4'(rx - 8'h30);
    else if (rx >= 8'h41 && rx <= 8'h46) rx_nib_c = 4'(rx - 8'h37);
    else if (rx >= 8'h61 && rx <= 8'h66) rx_nib_c = 4'(rx - 8'h57);
    else                                 rx_hex_c = 1'b0;
  end

  assign rmc_ok_c = (wcnt >= 8'd6) && (wbuf[47:24] == 24'h434D52);

  // Next-state and per-byte control decisions
  always_comb begin
    state_d   = state;
    start_c   = 1'b0;
    store_c   = 1'b0;
    take_hi_c = 1'b0;
    accept_c  = 1'b0;
    ck_err_c  = 1'b0;
    fr_err_c  = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        IDLE: begin
          if (rx == CH_DOLLAR) begin
            start_c = 1'b1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (rx == CH_DOLLAR) begin
            start_c = 1'b1;
          end else if (rx == CH_STAR) begin
            state_d = CK_HI;
          end else if (rx == CH_CR || rx == CH_LF || wcnt == MAX_CNT) begin
            fr_err_c = 1'b1;
            state_d  = IDLE;
          end else begin
            store_c = 1'b1;
          end
        end
        CK_HI: begin
          if (rx_hex_c) begin
            take_hi_c = 1'b1;
            state_d   = CK_LO;
          end else begin
            fr_err_c = 1'b1;
            state_d  = IDLE;
          end
        end
        CK_LO: begin
          state_d = IDLE;
          if (!rx_hex_c)                    fr_err_c = 1'b1;
          else if ({hi, rx_nib_c} != csum)  ck_err_c = 1'b1;
          else if (!MATCH_RMC || rmc_ok_c)  accept_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register, working buffer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wbuf           <= '0;
      wcnt           <= 8'd0;
      csum           <= 8'd0;
      hi             <= 4'd0;
      sentence       <= '0;
      sentence_len   <= 8'd0;
      sentence_valid <= 1'b0;
      cksum_err      <= 1'b0;
      frame_err      <= 1'b0;
      good_count     <= 16'd0;
      bad_count      <= 16'd0;
    end else begin
      state          <= state_d;
      sentence_valid <= accept_c;
      cksum_err      <= ck_err_c;
      frame_err      <= fr_err_c;
      if (start_c) begin
        wbuf <= {{(SENTENCE_BITS-8){1'b0}}, CH_DOLLAR};
        wcnt <= 8'd1;
        csum <= 8'd0;
      end
      if (store_c) begin
        wbuf[8*32'(wcnt) +: 8] <= rx;
        wcnt                   <= wcnt + 8'd1;
        csum                   <= csum ^ rx;
      end
      if (take_hi_c) hi <= rx_nib_c;
      if (accept_c) begin
        sentence     <= wbuf;
        sentence_len <= wcnt;
        if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
      end
      if ((ck_err_c || fr_err_c) && bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
    end
  end

  assign bus.sentence       = sentence;
  assign bus.sentence_len   = sentence_len;
  assign bus.sentence_valid = sentence_valid;
  assign bus.cksum_err      = cksum_err;
  assign bus.frame_err      = frame_err;
  assign bus.good_count     = good_count;
  assign bus.bad_count      = bad_count;
endmodule

// File: tb/tb_nmea_sentence_assembler.sv
// Directed bench for nmea_sentence_assembler: RMC-filtering instance plus an accept-any instance.
module tb_nmea_sentence_assembler;
  localparam int unsigned SB = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nmea_sentence_assembler_if #(.SENTENCE_BITS(SB)) if1 ();
  nmea_sentence_assembler_if #(.SENTENCE_BITS(SB)) if0 ();

  nmea_sentence_assembler #(.SENTENCE_BITS(SB), .MATCH_RMC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  nmea_sentence_assembler #(.SENTENCE_BITS(SB), .MATCH_RMC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));

  typedef struct {
    logic [255:0] msg;
    int           nv;
    int           nck;
    int           nfr;
    int           len;
    int           good;
    int           bad;
  } vec_t;

  vec_t vecs [11];
  int n_cmp = 0;
  int n_fail = 0;
  int nv1 = 0, nck1 = 0, nfr1 = 0, nv0 = 0;

  // Cumulative pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (if1.sentence_valid) nv1 <= nv1 + 1;
    if (if1.cksum_err)      nck1 <= nck1 + 1;
    if (if1.frame_err)      nfr1 <= nfr1 + 1;
    if (if0.sentence_valid) nv0 <= nv0 + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int msglen(input logic [255:0] m);
    int n = 0;
    while (n < 32 && m[8*n +: 8] != 8'h00) n++;
    return n;
  endfunction

  // Expected stored bytes: from the last '$' up to (not including) the following '*'
  function automatic logic [SB-1:0] model(input logic [255:0] m);
    logic [SB-1:0] r = '0;
    logic [7:0]    c;
    int            n = msglen(m);
    int            k = 0;
    bit            act = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = m[8*(n-1-i) +: 8];
      if (c == 8'h24) begin
        r = '0;
        r[7:0] = c;
        k = 1;
        act = 1'b1;
      end else if (act && c == 8'h2A) begin
        break;
      end else if (act) begin
        r[8*k +: 8] = c;
        k++;
      end
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    if1.rx_data = b; if0.rx_data = b;
    if1.rx_valid = 1'b1; if0.rx_valid = 1'b1;
    @(negedge clk);
    if1.rx_valid = 1'b0; if0.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_msg(input logic [255:0] m, input int maxgap);
    int n = msglen(m);
    for (int i = 0; i < n; i++)
      send(m[8*(n-1-i) +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  initial begin
    int b_v, b_ck, b_fr, b_v0;
    logic [15:0] b_g0;
    logic [SB-1:0] exp_s;

    //               msg                                   nv nck nfr len good bad
    vecs[0]  = '{256'("$GPRMC,1*56\r\n"),                  1, 0, 0, 8, 1, 0};
    vecs[1]  = '{256'("$GPRMC,1*57"),                      0, 1, 0, 8, 1, 1};
    vecs[2]  = '{256'("$GPRMC,19*6f"),                     1, 0, 0, 9, 2, 1};
    vecs[3]  = '{256'("$GPRMC,19*6F"),                     1, 0, 0, 9, 3, 1};
    vecs[4]  = '{256'("$GP$GPRMC,1*56"),                   1, 0, 0, 8, 4, 1};
    vecs[5]  = '{256'("$GPRMC,1\r"),                       0, 0, 1, 8, 4, 2};
    vecs[6]  = '{256'("$GPRMC,1*5G"),                      0, 0, 1, 8, 4, 3};
    vecs[7]  = '{256'("$GPRMC,1*$GPRMC,1*56"),             0, 0, 1, 8, 4, 4};
    vecs[8]  = '{256'("$*00"),                             0, 0, 0, 8, 4, 4};
    vecs[9]  = '{256'("$GPRMC,1A*0a"),                     0, 1, 0, 8, 4, 5};
    vecs[10] = '{256'("xx$GPRMC,1*56\n"),                  1, 0, 0, 8, 5, 5};

    if1.rx_data = 8'h00; if1.rx_valid = 1'b0;
    if0.rx_data = 8'h00; if0.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_len", 64'(if1.sentence_len), 64'd0);
    chk("rst_good", 64'(if1.good_count), 64'd0);
    chk("rst_bad", 64'(if1.bad_count), 64'd0);
    chk("rst_valid", 64'(if1.sentence_valid), 64'd0);
    chk("rst_sentence_zero", 64'(if1.sentence == '0), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      b_v = nv1; b_ck = nck1; b_fr = nfr1;
      send_msg(vecs[i].msg, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(nv1 - b_v), 64'(vecs[i].nv));
      chk($sformatf("v%0d_cksum_err", i), 64'(nck1 - b_ck), 64'(vecs[i].nck));
      chk($sformatf("v%0d_frame_err", i), 64'(nfr1 - b_fr), 64'(vecs[i].nfr));
      chk($sformatf("v%0d_len", i), 64'(if1.sentence_len), 64'(vecs[i].len));
      chk($sformatf("v%0d_good", i), 64'(if1.good_count), 64'(vecs[i].good));
      chk($sformatf("v%0d_bad", i), 64'(if1.bad_count), 64'(vecs[i].bad));
      if (vecs[i].nv != 0) begin
        exp_s = model(vecs[i].msg);
        chk($sformatf("v%0d_sentence", i), 64'(if1.sentence == exp_s), 64'd1);
      end
    end

    // Pulse lands exactly one cycle after the sampled lo digit
    send_msg(256'("$GPRMC,1*5"), 0);
    if1.rx_data = 8'h36; if0.rx_data = 8'h36;
    if1.rx_valid = 1'b1; if0.rx_valid = 1'b1;
    @(negedge clk);
    if1.rx_valid = 1'b0; if0.rx_valid = 1'b0;
    chk("lat_valid_hi", 64'(if1.sentence_valid), 64'd1);
    @(negedge clk);
    chk("lat_valid_lo", 64'(if1.sentence_valid), 64'd0);
    chk("lat_good", 64'(if1.good_count), 64'd6);
    chk("lat_sentence_lo64", if1.sentence[63:0], 64'h312C434D52504724);
    chk("lat_sentence_hi_zero", 64'(if1.sentence[SB-1:64] == '0), 64'd1);

    // Non-RMC type: filtered instance drops silently, accept-any instance takes it
    b_v = nv1; b_v0 = nv0; b_g0 = if0.good_count; b_ck = nck1; b_fr = nfr1;
    send_msg(256'("$GPGGA,1*4B"), 0);
    repeat (2) @(negedge clk);
    chk("gga_rmc_valid", 64'(nv1 - b_v), 64'd0);
    chk("gga_rmc_errs", 64'((nck1 - b_ck) + (nfr1 - b_fr)), 64'd0);
    chk("gga_rmc_good", 64'(if1.good_count), 64'd6);
    chk("gga_rmc_bad", 64'(if1.bad_count), 64'd5);
    chk("gga_any_valid", 64'(nv0 - b_v0), 64'd1);
    chk("gga_any_good", 64'(if0.good_count), 64'(b_g0 + 16'd1));
    chk("gga_any_len", 64'(if0.sentence_len), 64'd8);
    chk("gga_any_lo64", if0.sentence[63:0], 64'h312C414747504724);

    // Overflow: 127 payload bytes fill the buffer, the 128th raises frame_err
    b_fr = nfr1;
    send(8'h24, 0);
    for (int i = 0; i < 127; i++) send(8'h41, 0);
    repeat (2) @(negedge clk);
    chk("ovf_full_no_err", 64'(nfr1 - b_fr), 64'd0);
    send(8'h41, 0);
    @(negedge clk);
    chk("ovf_frame_err", 64'(nfr1 - b_fr), 64'd1);
    chk("ovf_bad", 64'(if1.bad_count), 64'd6);
    b_v = nv1;
    send_msg(256'("$GPRMC,1*56"), 0);
    repeat (2) @(negedge clk);
    chk("ovf_after_valid", 64'(nv1 - b_v), 64'd1);
    chk("ovf_after_good", 64'(if1.good_count), 64'd7);

    // Idle gaps between bytes give the same result as back-to-back
    b_v = nv1; b_ck = nck1; b_fr = nfr1;
    send_msg(256'("$GPRMC,19*6F"), 5);
    repeat (2) @(negedge clk);
    chk("gap_valid", 64'(nv1 - b_v), 64'd1);
    chk("gap_errs", 64'((nck1 - b_ck) + (nfr1 - b_fr)), 64'd0);
    chk("gap_len", 64'(if1.sentence_len), 64'd9);
    chk("gap_good", 64'(if1.good_count), 64'd8);
    exp_s = model(256'("$GPRMC,19*6F"));
    chk("gap_sentence", 64'(if1.sentence == exp_s), 64'd1);

    // Reset mid-sentence discards the partial frame with no error
    b_v = nv1; b_ck = nck1; b_fr = nfr1;
    send_msg(256'("$GPRMC,"), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_msg(256'("1*56"), 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", 64'(nv1 - b_v), 64'd0);
    chk("mid_rst_errs", 64'((nck1 - b_ck) + (nfr1 - b_fr)), 64'd0);
    chk("mid_rst_good", 64'(if1.good_count), 64'd0);
    chk("mid_rst_bad", 64'(if1.bad_count), 64'd0);
    chk("mid_rst_len", 64'(if1.sentence_len), 64'd0);
    chk("mid_rst_sentence_zero", 64'(if1.sentence == '0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
